// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic_light / ped_walk_ctrl family:
// light phase codes, pedestrian FSM states and a small decode helper.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED     = 2'b00;
  localparam logic [1:0] LIGHT_GREEN   = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW  = 2'b10;
  localparam logic [1:0] LIGHT_INVALID = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_RED = 2'b01,
    WALK     = 2'b10,
    FLASH    = 2'b11
  } ped_state_t;

  // Only the RED code counts as RED; the invalid code is treated as non-RED.
  function automatic logic is_red(input logic [1:0] code);
    return (code == LIGHT_RED);
  endfunction

endpackage

// File: rtl/ped_phase_counter.sv
// 8-bit loadable down-counter shared by the WALK and FLASH phases.
// Load has priority over decrement; the counter holds at zero.
module ped_phase_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic [7:0] count,
  output logic       zero
);

  // Load, or count down towards zero while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/ped_walk_ctrl.sv
// Pedestrian walk-signal controller. Latches a button request, grants WALK
// only on entry to a RED phase, follows it with a flashing DONT_WALK
// countdown, and drops back to steady DONT_WALK as soon as RED ends.
module ped_walk_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned WALK_CYCLES  = 8,
  parameter int unsigned FLASH_CYCLES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] light,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       flash,
  output logic [3:0] countdown,
  output logic       req_pending,
  output logic       fault
);

  localparam logic [7:0] WALK_LOAD  = 8'(WALK_CYCLES - 1);
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_CYCLES - 1);

  ped_state_t state;
  logic       btn_q;
  logic [1:0] light_q;

  logic       btn_rise;
  logic       red_entry;
  logic       light_red;
  logic       abort;

  logic       cnt_load;
  logic [7:0] cnt_load_val;
  logic       cnt_en;
  logic [7:0] cnt_count;
  logic       cnt_zero;

  assign light_red = is_red(light);
  assign btn_rise  = ped_btn & ~btn_q;
  assign red_entry = light_red & ~is_red(light_q);
  // Leaving RED while pedestrians may be crossing always wins.
  assign abort     = ((state == WALK) || (state == FLASH)) && !light_red;

  // Counter control: load on phase entry, decrement while a phase runs.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = WALK_LOAD;
    cnt_en       = 1'b0;
    case (state)
      WAIT_RED: begin
        if (red_entry) cnt_load = 1'b1;
      end
      WALK: begin
        if (!abort) begin
          if (cnt_zero) begin
            cnt_load     = 1'b1;
            cnt_load_val = FLASH_LOAD;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      FLASH: begin
        if (!abort && !cnt_zero) cnt_en = 1'b1;
      end
      default: ;
    endcase
  end

  ped_phase_counter u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  // Edge-detect history, sticky fault, FSM and registered indications.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      btn_q       <= 1'b0;
      light_q     <= LIGHT_RED;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      flash       <= 1'b0;
      countdown   <= 4'd0;
      req_pending <= 1'b0;
      fault       <= 1'b0;
    end else begin
      btn_q   <= ped_btn;
      light_q <= light;
      if (light == LIGHT_INVALID) fault <= 1'b1;

      if (abort) begin
        state     <= IDLE;
        walk      <= 1'b0;
        dont_walk <= 1'b1;
        flash     <= 1'b0;
        countdown <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            // A coincident red_entry is deliberately not used here.
            if (btn_rise) begin
              state       <= WAIT_RED;
              req_pending <= 1'b1;
            end
          end
          WAIT_RED: begin
            if (red_entry) begin
              state       <= WALK;
              walk        <= 1'b1;
              dont_walk   <= 1'b0;
              req_pending <= 1'b0;
            end else if (btn_rise) begin
              req_pending <= 1'b1;
            end
          end
          WALK: begin
            if (cnt_zero) begin
              state     <= FLASH;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
              flash     <= 1'b1;
              countdown <= FLASH_LOAD[3:0];
            end
          end
          FLASH: begin
            if (cnt_zero) begin
              state     <= IDLE;
              dont_walk <= 1'b1;
              flash     <= 1'b0;
              countdown <= 4'd0;
            end else begin
              dont_walk <= ~dont_walk;
              countdown <= 4'(cnt_count - 8'd1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ped_walk_ctrl.sv
// Scoreboard bench for ped_walk_ctrl: the driver applies one input vector
// per cycle, a behavioural model predicts the post-edge outputs and queues
// them, and a monitor compares the DUT against the queue after each edge.
module tb_ped_walk_ctrl;

  localparam int WALK_N  = 4;
  localparam int FLASH_N = 3;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] G = 2'b01;
  localparam logic [1:0] Y = 2'b10;
  localparam logic [1:0] X = 2'b11;

  typedef struct packed {
    logic       walk;
    logic       dont_walk;
    logic       flash;
    logic [3:0] countdown;
    logic       req_pending;
    logic       fault;
  } outs_t;

  logic       clk;
  logic       reset;
  logic [1:0] light;
  logic       ped_btn;
  logic       walk;
  logic       dont_walk;
  logic       flash;
  logic [3:0] countdown;
  logic       req_pending;
  logic       fault;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  outs_t exp_q[$];

  // Reference model: walking/flashing expressed as cycles left to show.
  int   m_walk_left;
  int   m_flash_left;
  bit   m_armed;
  bit   m_pending;
  bit   m_fault;
  bit   m_btn_prev;
  logic [1:0] m_light_prev;

  ped_walk_ctrl #(
    .WALK_CYCLES  (WALK_N),
    .FLASH_CYCLES (FLASH_N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .light       (light),
    .ped_btn     (ped_btn),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .flash       (flash),
    .countdown   (countdown),
    .req_pending (req_pending),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t dut_outs();
    outs_t o;
    o.walk        = walk;
    o.dont_walk   = dont_walk;
    o.flash       = flash;
    o.countdown   = countdown;
    o.req_pending = req_pending;
    o.fault       = fault;
    return o;
  endfunction

  function automatic outs_t model_outs();
    outs_t o;
    o.walk        = (m_walk_left > 0);
    o.flash       = (m_flash_left > 0);
    o.countdown   = (m_flash_left > 0) ? 4'(m_flash_left - 1) : 4'd0;
    // During FLASH the indication is on for even-numbered flash cycles.
    if (m_walk_left > 0)       o.dont_walk = 1'b0;
    else if (m_flash_left > 0) o.dont_walk = (((FLASH_N - m_flash_left) % 2) == 0);
    else                       o.dont_walk = 1'b1;
    o.req_pending = m_pending;
    o.fault       = m_fault;
    return o;
  endfunction

  task automatic model_reset();
    m_walk_left  = 0;
    m_flash_left = 0;
    m_armed      = 0;
    m_pending    = 0;
    m_fault      = 0;
    m_btn_prev   = 0;
    m_light_prev = R;
  endtask

  task automatic model_step(input bit btn, input logic [1:0] lt);
    bit rise, red_now, entry;
    rise    = btn && !m_btn_prev;
    red_now = (lt == R);
    entry   = red_now && (m_light_prev != R);
    if (m_walk_left > 0 || m_flash_left > 0) begin
      if (!red_now) begin
        m_walk_left  = 0;
        m_flash_left = 0;
      end else if (m_walk_left > 0) begin
        m_walk_left = m_walk_left - 1;
        if (m_walk_left == 0) m_flash_left = FLASH_N;
      end else begin
        m_flash_left = m_flash_left - 1;
      end
    end else if (m_armed) begin
      if (entry) begin
        m_walk_left = WALK_N;
        m_armed     = 0;
        m_pending   = 0;
      end else if (rise) begin
        m_pending = 1;
      end
    end else if (rise) begin
      m_armed   = 1;
      m_pending = 1;
    end
    if (lt == X) m_fault = 1;
    m_btn_prev   = btn;
    m_light_prev = lt;
  endtask

  task automatic compare(input string name, input outs_t act, input outs_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got walk=%b dw=%b flash=%b cd=%0d req=%b fault=%b, expected walk=%b dw=%b flash=%b cd=%0d req=%b fault=%b",
               name, act.walk, act.dont_walk, act.flash, act.countdown, act.req_pending, act.fault,
               req.walk, req.dont_walk, req.flash, req.countdown, req.req_pending, req.fault);
    end
  endtask

  // Apply one input vector and queue the outputs expected after the next edge.
  task automatic step(input bit btn, input logic [1:0] lt);
    @(negedge clk);
    ped_btn = btn;
    light   = lt;
    model_step(btn, lt);
    exp_q.push_back(model_outs());
  endtask

  task automatic hold(input int n, input logic [1:0] lt);
    for (int i = 0; i < n; i++) step(1'b0, lt);
  endtask

  // Monitor: one comparison per clocked transaction.
  initial begin
    outs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        compare($sformatf("txn%0d", txn), dut_outs(), e);
        $display("txn %0d: light=%b btn=%b walk=%b dw=%b flash=%b cd=%0d req=%b fault=%b",
                 txn, light, ped_btn, walk, dont_walk, flash, countdown, req_pending, fault);
      end
    end
  end

  outs_t reset_vals;

  initial begin
    int len;
    logic [1:0] seq [3];
    reset_vals = '{walk: 1'b0, dont_walk: 1'b1, flash: 1'b0, countdown: 4'd0,
                   req_pending: 1'b0, fault: 1'b0};
    reset   = 1'b0;
    ped_btn = 1'b0;
    light   = G;

    // Asynchronous reset applied between clock edges.
    #3 reset = 1'b1;
    #1 compare("reset_async", dut_outs(), reset_vals);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Full cycle: request in GREEN, then RED -> WALK, FLASH, IDLE.
    hold(2, G);
    step(1'b1, G);
    step(1'b0, G);
    hold(10, R);
    hold(2, G);

    // Abort: RED ends on the second WALK cycle.
    step(1'b1, G);
    step(1'b0, G);
    hold(2, R);
    hold(4, Y);

    // Request made mid-RED waits for the next RED entry.
    hold(2, R);
    step(1'b1, R);
    hold(4, R);
    hold(2, G);
    hold(2, Y);
    hold(10, R);

    // Simultaneous request and RED entry from IDLE.
    hold(2, G);
    step(1'b1, R);
    step(1'b0, R);
    hold(2, G);
    hold(10, R);

    // Single invalid code while IDLE, then a normal request.
    step(1'b0, G);
    step(1'b0, X);
    hold(2, G);
    step(1'b1, G);
    step(1'b0, G);
    hold(10, R);

    // Reset during FLASH with countdown = 1.
    hold(2, G);
    step(1'b1, G);
    step(1'b0, R);
    hold(WALK_N + 1, R);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 compare("reset_in_flash", dut_outs(), reset_vals);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Randomised light phases with occasional invalid codes and button activity.
    seq[0] = G; seq[1] = Y; seq[2] = R;
    for (int p = 0; p < 90; p++) begin
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        logic [1:0] lt;
        bit b;
        lt = seq[p % 3];
        if ($urandom_range(0, 39) == 0) lt = X;
        b = ($urandom_range(0, 3) == 0);
        step(b, lt);
      end
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
